// File: rtl/axi_lite_ic_pkg.sv
// Shared definitions for the AXI-Lite interconnect arbiters.
// The read-side and write-side arbiters both use:
//   arb_state_e   - arbiter FSM state encoding (IDLE / ADDR / DATA)
//   MAX_MASTERS   - upper bound on master count accepted by onehot_to_bin
//   onehot_to_bin - converts a one-hot grant vector to a binary index
package axi_lite_ic_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADDR = 2'd1,
    DATA = 2'd2
  } arb_state_e;

  localparam int unsigned MAX_MASTERS = 64;

  // With a zero vector this returns 0. Callers zero-extend narrower grant
  // vectors into this argument.
  function automatic int unsigned onehot_to_bin(input logic [MAX_MASTERS-1:0] oh);
    int unsigned idx;
    idx = 0;
    for (int i = 0; i < MAX_MASTERS; i++) begin
      if (oh[i]) idx = idx | unsigned'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/ar_rr_arbiter_s_if.sv
// AR/R control bundle for one slave port of the AXI-Lite read path.
//   m_axi_arvalid_i      per-master ARVALID
//   m_axi_arready_o      ARREADY routed to the granted master only
//   s_axi_arvalid_o      ARVALID forwarded to the slave
//   s_axi_arready_i      slave ARREADY
//   s_axi_rvalid_i       slave RVALID
//   s_axi_rready_i       RREADY returned by the R dispatcher
//   ar_grant_o           one-hot AR mux select (ARADDR/ARPROT path)
//   Master_ID_Selected_o one-hot select for the R dispatcher
//   grant_id_o           binary index of the current grant
//   busy_o               transaction in progress
// Modport slave is the arbiter side; modport master is the surrounding fabric.
interface ar_rr_arbiter_s_if #(
  parameter int NUM_MASTERS = 16,
  parameter int MASTER_ID_W = $clog2(NUM_MASTERS)
);
  logic [NUM_MASTERS-1:0] m_axi_arvalid_i;
  logic [NUM_MASTERS-1:0] m_axi_arready_o;
  logic                   s_axi_arvalid_o;
  logic                   s_axi_arready_i;
  logic                   s_axi_rvalid_i;
  logic                   s_axi_rready_i;
  logic [NUM_MASTERS-1:0] ar_grant_o;
  logic [NUM_MASTERS-1:0] Master_ID_Selected_o;
  logic [MASTER_ID_W-1:0] grant_id_o;
  logic                   busy_o;

  modport slave (
    input  m_axi_arvalid_i, s_axi_arready_i, s_axi_rvalid_i, s_axi_rready_i,
    output m_axi_arready_o, s_axi_arvalid_o, ar_grant_o, Master_ID_Selected_o,
           grant_id_o, busy_o
  );

  modport master (
    output m_axi_arvalid_i, s_axi_arready_i, s_axi_rvalid_i, s_axi_rready_i,
    input  m_axi_arready_o, s_axi_arvalid_o, ar_grant_o, Master_ID_Selected_o,
           grant_id_o, busy_o
  );
endinterface

// File: rtl/rr_priority_picker.sv
// Combinational find-first-set starting at a rotating pointer.
//   req   - request vector
//   ptr   - index searched first; the search wraps from NUM_MASTERS-1 to 0
//   grant - one-hot winner (zero when no request)
//   valid - at least one request present
module rr_priority_picker #(
  parameter int NUM_MASTERS = 16,
  parameter int MASTER_ID_W = $clog2(NUM_MASTERS)
) (
  input  logic [NUM_MASTERS-1:0] req,
  input  logic [MASTER_ID_W-1:0] ptr,
  output logic [NUM_MASTERS-1:0] grant,
  output logic                   valid
);

  int idx;

  always_comb begin
    grant = '0;
    valid = 1'b0;
    idx   = 0;
    for (int k = 0; k < NUM_MASTERS; k++) begin
      idx = (int'(ptr) + k) % NUM_MASTERS;
      if (!valid && req[idx]) begin
        grant[idx] = 1'b1;
        valid      = 1'b1;
      end
    end
  end

endmodule

// File: rtl/ar_rr_arbiter_s.sv
// Per-slave read-path controller: round-robin arbitration of AR requests,
// grant held until the single-beat R response completes.
//   clk   - system clock, rising edge
//   rst_n - asynchronous active-low reset
//   bus   - AR/R control bundle (slave modport of ar_rr_arbiter_s_if)
// ar_grant_o, Master_ID_Selected_o, grant_id_o and busy_o are registered.
// s_axi_arvalid_o and m_axi_arready_o are combinational from the registered
// grant and live inputs. Arbitration itself only feeds registers.
module ar_rr_arbiter_s
  import axi_lite_ic_pkg::*;
#(
  parameter int NUM_MASTERS = 16,
  parameter int MASTER_ID_W = $clog2(NUM_MASTERS)
) (
  input  logic               clk,
  input  logic               rst_n,
  ar_rr_arbiter_s_if.slave   bus
);

  arb_state_e             state, state_nxt;
  logic [NUM_MASTERS-1:0] grant, grant_nxt;
  logic [MASTER_ID_W-1:0] rr_ptr, rr_ptr_nxt;
  logic [NUM_MASTERS-1:0] pick_grant;
  logic                   pick_valid;
  logic [MASTER_ID_W-1:0] grant_idx;
  logic                   s_arvalid;

  logic [NUM_MASTERS-1:0] ar_grant_q;
  logic [NUM_MASTERS-1:0] msel_q;
  logic [MASTER_ID_W-1:0] grant_id_q;
  logic                   busy_q;

  rr_priority_picker #(
    .NUM_MASTERS (NUM_MASTERS),
    .MASTER_ID_W (MASTER_ID_W)
  ) u_picker (
    .req   (bus.m_axi_arvalid_i),
    .ptr   (rr_ptr),
    .grant (pick_grant),
    .valid (pick_valid)
  );

  assign grant_idx = MASTER_ID_W'(onehot_to_bin(MAX_MASTERS'(grant)));

  // A granted master that lowers ARVALID in ADDR also lowers s_arvalid,
  // which is how the abort back to IDLE is detected.
  assign s_arvalid           = (state == ADDR) && |(bus.m_axi_arvalid_i & grant);
  assign bus.s_axi_arvalid_o = s_arvalid;
  assign bus.m_axi_arready_o = (state == ADDR) ?
                               (grant & {NUM_MASTERS{bus.s_axi_arready_i}}) : '0;

  always_comb begin
    state_nxt  = state;
    grant_nxt  = grant;
    rr_ptr_nxt = rr_ptr;
    unique case (state)
      IDLE: begin
        if (pick_valid) begin
          grant_nxt = pick_grant;
          state_nxt = ADDR;
        end else begin
          grant_nxt = '0;
        end
      end
      ADDR: begin
        if (s_arvalid && bus.s_axi_arready_i) begin
          state_nxt = DATA;
        end else if (!s_arvalid) begin
          // Abort without rotating the pointer.
          state_nxt = IDLE;
          grant_nxt = '0;
        end
      end
      DATA: begin
        if (bus.s_axi_rvalid_i && bus.s_axi_rready_i) begin
          state_nxt  = IDLE;
          grant_nxt  = '0;
          rr_ptr_nxt = (grant_idx == MASTER_ID_W'(NUM_MASTERS - 1)) ?
                       '0 : grant_idx + MASTER_ID_W'(1);
        end
      end
      default: begin
        state_nxt = IDLE;
        grant_nxt = '0;
      end
    endcase
  end

  // Registered outputs are decoded from next state/grant so they line up
  // with the state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      grant      <= '0;
      rr_ptr     <= '0;
      ar_grant_q <= '0;
      msel_q     <= '0;
      grant_id_q <= '0;
      busy_q     <= 1'b0;
    end else begin
      state      <= state_nxt;
      grant      <= grant_nxt;
      rr_ptr     <= rr_ptr_nxt;
      ar_grant_q <= (state_nxt == ADDR) ? grant_nxt : '0;
      msel_q     <= (state_nxt == DATA) ? grant_nxt : '0;
      grant_id_q <= MASTER_ID_W'(onehot_to_bin(MAX_MASTERS'(grant_nxt)));
      busy_q     <= (state_nxt != IDLE);
    end
  end

  assign bus.ar_grant_o           = ar_grant_q;
  assign bus.Master_ID_Selected_o = msel_q;
  assign bus.grant_id_o           = grant_id_q;
  assign bus.busy_o               = busy_q;

endmodule

// File: tb/tb_ar_rr_arbiter_s.sv
module tb_ar_rr_arbiter_s;
  localparam int N = 16;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  ar_rr_arbiter_s_if #(.NUM_MASTERS(N)) bus ();

  ar_rr_arbiter_s #(.NUM_MASTERS(N)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  int total = 0;
  int bad   = 0;

  // Reference model: phase 0 = idle, 1 = address, 2 = data.
  int m_phase, m_g, m_ptr;

  typedef struct {
    logic [15:0] arv;
    logic        sar, rv, rr;
    logic [15:0] eg, es, ea;
    logic        esv, eb;
    logic [3:0]  eid;
  } vec_t;
  vec_t tbl[6];

  int grants[$];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h required=%h", nm, act, exp);
    end
  endtask

  function automatic int pick(input logic [N-1:0] req, input int p);
    for (int k = 0; k < N; k++) begin
      if (req[(p + k) % N]) return (p + k) % N;
    end
    return -1;
  endfunction

  task automatic model_reset();
    m_phase = 0; m_g = 0; m_ptr = 0;
  endtask

  task automatic model_check();
    logic [15:0] oh;
    oh = 16'(1) << m_g;
    chk("m_ar_grant", 32'(bus.ar_grant_o), (m_phase == 1) ? 32'(oh) : 32'd0);
    chk("m_msel", 32'(bus.Master_ID_Selected_o), (m_phase == 2) ? 32'(oh) : 32'd0);
    chk("m_grant_id", 32'(bus.grant_id_o), (m_phase != 0) ? 32'(m_g) : 32'd0);
    chk("m_busy", 32'(bus.busy_o), 32'(m_phase != 0));
    chk("m_s_arvalid", 32'(bus.s_axi_arvalid_o),
        32'(m_phase == 1 && bus.m_axi_arvalid_i[m_g]));
    chk("m_m_arready", 32'(bus.m_axi_arready_o),
        (m_phase == 1 && bus.s_axi_arready_i) ? 32'(oh) : 32'd0);
  endtask

  task automatic model_step();
    if (!rst_n) begin
      model_reset();
    end else begin
      case (m_phase)
        0: if (bus.m_axi_arvalid_i != 0) begin
             m_g = pick(bus.m_axi_arvalid_i, m_ptr);
             m_phase = 1;
           end
        1: if (!bus.m_axi_arvalid_i[m_g]) m_phase = 0;
           else if (bus.s_axi_arready_i) m_phase = 2;
        default: if (bus.s_axi_rvalid_i && bus.s_axi_rready_i) begin
             m_phase = 0;
             m_ptr = (m_g + 1) % N;
           end
      endcase
    end
  endtask

  task automatic drive(input logic [15:0] arv, input logic sar, input logic rv, input logic rr);
    bus.m_axi_arvalid_i = arv;
    bus.s_axi_arready_i = sar;
    bus.s_axi_rvalid_i  = rv;
    bus.s_axi_rready_i  = rr;
  endtask

  // Called just after a falling edge with inputs already applied.
  task automatic tick();
    #1 model_check();
    @(posedge clk);
    model_step();
    @(negedge clk);
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_ar_grant"}, 32'(bus.ar_grant_o), 32'd0);
    chk({tag, "_msel"}, 32'(bus.Master_ID_Selected_o), 32'd0);
    chk({tag, "_grant_id"}, 32'(bus.grant_id_o), 32'd0);
    chk({tag, "_busy"}, 32'(bus.busy_o), 32'd0);
    chk({tag, "_s_arvalid"}, 32'(bus.s_axi_arvalid_o), 32'd0);
    chk({tag, "_m_arready"}, 32'(bus.m_axi_arready_o), 32'd0);
  endtask

  task automatic pulse_reset();
    rst_n = 1'b0;
    model_reset();
    #1 rst_n = 1'b1;
  endtask

  initial begin
    // Single master 5, stray R in ADDR, handshake, R, back to IDLE.
    tbl[0] = '{16'h0020, 1'b0, 1'b0, 1'b0, 16'h0000, 16'h0000, 16'h0000, 1'b0, 1'b0, 4'd0};
    tbl[1] = '{16'h0020, 1'b0, 1'b1, 1'b1, 16'h0020, 16'h0000, 16'h0000, 1'b1, 1'b1, 4'd5};
    tbl[2] = '{16'h0020, 1'b0, 1'b0, 1'b0, 16'h0020, 16'h0000, 16'h0000, 1'b1, 1'b1, 4'd5};
    tbl[3] = '{16'h0020, 1'b1, 1'b0, 1'b0, 16'h0020, 16'h0000, 16'h0020, 1'b1, 1'b1, 4'd5};
    tbl[4] = '{16'h0000, 1'b0, 1'b1, 1'b1, 16'h0000, 16'h0020, 16'h0000, 1'b0, 1'b1, 4'd5};
    tbl[5] = '{16'h0000, 1'b0, 1'b0, 1'b0, 16'h0000, 16'h0000, 16'h0000, 1'b0, 1'b0, 4'd0};

    // Reset with every master requesting.
    drive(16'hFFFF, 1'b0, 1'b0, 1'b0);
    rst_n = 1'b0;
    model_reset();
    repeat (2) @(negedge clk);
    #1 chk_all_zero("reset");
    rst_n = 1'b1;
    tick();
    #1 chk("post_reset_ar_grant", 32'(bus.ar_grant_o), 32'h0001);
    chk("post_reset_grant_id", 32'(bus.grant_id_o), 32'd0);
    drive(16'h0000, 1'b0, 1'b0, 1'b0);
    tick();

    for (int i = 0; i < 6; i++) begin
      drive(tbl[i].arv, tbl[i].sar, tbl[i].rv, tbl[i].rr);
      #1;
      chk($sformatf("vec%0d_ar_grant", i), 32'(bus.ar_grant_o), 32'(tbl[i].eg));
      chk($sformatf("vec%0d_msel", i), 32'(bus.Master_ID_Selected_o), 32'(tbl[i].es));
      chk($sformatf("vec%0d_m_arready", i), 32'(bus.m_axi_arready_o), 32'(tbl[i].ea));
      chk($sformatf("vec%0d_s_arvalid", i), 32'(bus.s_axi_arvalid_o), 32'(tbl[i].esv));
      chk($sformatf("vec%0d_busy", i), 32'(bus.busy_o), 32'(tbl[i].eb));
      chk($sformatf("vec%0d_grant_id", i), 32'(bus.grant_id_o), 32'(tbl[i].eid));
      tick();
    end

    // Stray response in IDLE.
    drive(16'h0000, 1'b0, 1'b1, 1'b1);
    repeat (2) begin
      tick();
      #1 chk("stray_idle_msel", 32'(bus.Master_ID_Selected_o), 32'd0);
      chk("stray_idle_busy", 32'(bus.busy_o), 32'd0);
    end

    // Round-robin with wrap: masters 0, 1, 15 requesting continuously.
    pulse_reset();
    drive(16'h8003, 1'b1, 1'b1, 1'b1);
    for (int c = 0; c < 12; c++) begin
      #1 if (bus.ar_grant_o != 0) grants.push_back(int'(bus.grant_id_o));
      tick();
    end
    chk("rr_count", 32'(grants.size()), 32'd4);
    if (grants.size() >= 4) begin
      chk("rr_order0", 32'(grants[0]), 32'd0);
      chk("rr_order1", 32'(grants[1]), 32'd1);
      chk("rr_order2", 32'(grants[2]), 32'd15);
      chk("rr_order3", 32'(grants[3]), 32'd0);
    end
    drive(16'h0000, 1'b0, 1'b0, 1'b0);
    repeat (3) tick();

    // Hold under contention: master 3 granted, 7 waiting, slave stalls.
    pulse_reset();
    drive(16'h0088, 1'b0, 1'b0, 1'b0);
    tick();
    repeat (5) begin
      #1 chk("hold_ar_grant", 32'(bus.ar_grant_o), 32'h0008);
      chk("hold_arready7", 32'(bus.m_axi_arready_o[7]), 32'd0);
      tick();
    end
    drive(16'h0088, 1'b1, 1'b0, 1'b0);
    tick();
    drive(16'h0080, 1'b0, 1'b1, 1'b1);
    tick();
    drive(16'h0000, 1'b0, 1'b0, 1'b0);
    tick();

    // Stray R in ADDR, then ARVALID drop abort; pointer must stay at 0.
    pulse_reset();
    drive(16'h0010, 1'b0, 1'b0, 1'b0);
    tick();
    drive(16'h0010, 1'b0, 1'b1, 1'b1);
    tick();
    #1 chk("stray_addr_ar_grant", 32'(bus.ar_grant_o), 32'h0010);
    chk("stray_addr_msel", 32'(bus.Master_ID_Selected_o), 32'd0);
    drive(16'h0000, 1'b0, 1'b0, 1'b0);
    tick();
    #1 chk("drop_busy", 32'(bus.busy_o), 32'd0);
    drive(16'h0021, 1'b0, 1'b0, 1'b0);
    tick();
    #1 chk("drop_ptr_kept", 32'(bus.grant_id_o), 32'd0);

    // Reset in DATA aborts at once.
    drive(16'h0021, 1'b1, 1'b0, 1'b0);
    tick();
    #1 chk("data_msel", 32'(bus.Master_ID_Selected_o), 32'h0001);
    rst_n = 1'b0;
    model_reset();
    #1 chk_all_zero("rst_in_data");
    @(negedge clk);
    rst_n = 1'b1;

    // Randomized traffic against the model.
    for (int c = 0; c < 3000; c++) begin
      drive(16'($urandom & $urandom), 1'($urandom_range(0, 1)),
            1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      tick();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
